// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues in-order word fetches against a req/gnt/rvalid memory port
// and buffers {pc, inst} pairs for decode behind a valid/ready handshake.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
);
  localparam int unsigned   AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned   CW      = AW + 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [31:0]   NOP     = 32'h0000_0013;

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [AW-1:0] q_head_q, q_head_d, q_tail_q, q_tail_d;
  logic [AW-1:0] pf_head_q, pf_head_d, pf_tail_q, pf_tail_d;

  logic [31:0] q_pc_q   [DEPTH];
  logic [31:0] q_inst_q [DEPTH];
  logic [31:0] pf_pc_q  [DEPTH];

  logic          pop, accept, drop, push;
  logic [CW-1:0] credit_used;

  assign imem_addr = pc_q;

  always_comb begin
    id_valid    = !rst && (count_q != '0);
    id_inst     = id_valid ? q_inst_q[q_head_q] : NOP;
    id_pc       = id_valid ? q_pc_q[q_head_q] : 32'h0;
    pop         = id_valid && id_ready;
    // Queue slots already spoken for, counting the entry decode is taking this cycle as free.
    credit_used = count_q + outst_q - CW'(pop);
    imem_req    = !rst && !redirect && (credit_used < DEPTH_C)
                  && ((outst_q + discard_q) < DEPTH_C);
    accept      = imem_req && imem_gnt;
    drop        = imem_rvalid && (redirect || (discard_q != '0));
    push        = imem_rvalid && !drop;
  end

  always_comb begin
    pc_d      = pc_q;
    count_d   = count_q;
    outst_d   = outst_q;
    discard_d = discard_q;
    q_head_d  = q_head_q;
    q_tail_d  = q_tail_q;
    pf_head_d = pf_head_q;
    pf_tail_d = pf_tail_q;

    // The in-flight PC FIFO tracks every granted request, stale or not, so it is never flushed.
    if (accept)      pf_tail_d = pf_tail_q + 1'b1;
    if (imem_rvalid) pf_head_d = pf_head_q + 1'b1;

    if (redirect) begin
      pc_d      = redirect_pc & ~32'h3;
      count_d   = '0;
      q_head_d  = '0;
      q_tail_d  = '0;
      outst_d   = '0;
      discard_d = discard_q + outst_q - CW'(imem_rvalid);
    end else begin
      if (accept) pc_d = pc_q + 32'd4;
      if (push)   q_tail_d = q_tail_q + 1'b1;
      if (pop)    q_head_d = q_head_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
      outst_d = outst_q + CW'(accept) - CW'(push);
      if (imem_rvalid && (discard_q != '0)) discard_d = discard_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      count_q   <= '0;
      outst_q   <= '0;
      discard_q <= '0;
      q_head_q  <= '0;
      q_tail_q  <= '0;
      pf_head_q <= '0;
      pf_tail_q <= '0;
    end else begin
      pc_q      <= pc_d;
      count_q   <= count_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
      q_head_q  <= q_head_d;
      q_tail_q  <= q_tail_d;
      pf_head_q <= pf_head_d;
      pf_tail_q <= pf_tail_d;
    end
  end

  // Payload storage carries no reset; validity is tracked entirely by the counters above.
  always_ff @(posedge clk) begin
    if (accept) pf_pc_q[pf_tail_q] <= pc_q;
    if (push) begin
      q_pc_q[q_tail_q]   <= pf_pc_q[pf_head_q];
      q_inst_q[q_tail_q] <= imem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && !pop && (count_q == DEPTH_C)));
      assert (!(imem_rvalid && (outst_q == '0) && (discard_q == '0)));
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model plus an instruction-stream
// scoreboard (expected PC sequence restarting at each redirect/reset).
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] XMASK    = 32'hAAAA_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_inst;
  logic [31:0] id_pc;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_inst     (id_inst),
    .id_pc       (id_pc)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  // memory model: granted addresses in order, each with the cycle its response may appear
  logic [31:0] mem_addr_q [$];
  int          mem_due_q  [$];
  int          mem_lat = 1;
  int          gnt_pct = 100;

  // reference model of the instruction stream
  logic [31:0] exp_pc     = RESET_PC;
  logic [31:0] exp_req_pc = RESET_PC;
  int          delivered  = 0;
  bit          prev_redirect = 1'b0;

  logic        obs_req, obs_gnt, obs_valid;
  logic [31:0] obs_addr, obs_pc, obs_inst;

  function automatic bit rvalid_due();
    return (mem_due_q.size() > 0) && (mem_due_q[0] <= cyc);
  endfunction

  task automatic tick(input bit r, input bit rd, input logic [31:0] rpc, input bit rdy);
    logic [31:0] a;
    int          d;
    @(negedge clk);
    rst         = r;
    redirect    = rd;
    redirect_pc = rpc;
    id_ready    = rdy;
    if (!r && rvalid_due()) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_addr_q[0] ^ XMASK;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    imem_gnt = ($urandom_range(99) < gnt_pct);
    #1;
    obs_req   = imem_req;
    obs_gnt   = imem_gnt;
    obs_addr  = imem_addr;
    obs_valid = id_valid;
    obs_pc    = id_pc;
    obs_inst  = id_inst;

    if (!r) begin
      if (prev_redirect) begin
        tests_run++;
        if (obs_valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL sb_valid_after_redirect: cyc=%0d id_valid=%b want 0", cyc, obs_valid);
        end
      end
      if (obs_valid === 1'b0) begin
        tests_run++;
        if (obs_inst !== NOP || obs_pc !== 32'h0) begin
          tests_failed++;
          $display("FAIL sb_idle_outputs: cyc=%0d id_inst=%h id_pc=%h want %h 0", cyc, obs_inst, obs_pc, NOP);
        end
      end
      if (obs_req === 1'b1) begin
        tests_run++;
        if (obs_addr !== exp_req_pc || rd) begin
          tests_failed++;
          $display("FAIL sb_req_addr: cyc=%0d addr=%h redirect=%b want addr %h and no redirect", cyc, obs_addr, rd, exp_req_pc);
        end
        tests_run++;
        if (mem_addr_q.size() >= DEPTH) begin
          tests_failed++;
          $display("FAIL sb_credit: cyc=%0d imem_req=1 with %0d in flight, want 0", cyc, mem_addr_q.size());
        end
      end
      if (obs_valid === 1'b1 && rdy && !rd) begin
        tests_run++;
        if (obs_pc !== exp_pc || obs_inst !== (exp_pc ^ XMASK)) begin
          tests_failed++;
          $display("FAIL sb_deliver: cyc=%0d got pc=%h inst=%h want pc=%h inst=%h", cyc, obs_pc, obs_inst, exp_pc, exp_pc ^ XMASK);
        end
        $display("[TB] cyc=%0d deliver pc=%h inst=%h", cyc, obs_pc, obs_inst);
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
    end

    if (imem_rvalid) begin
      a = mem_addr_q.pop_front();
      d = mem_due_q.pop_front();
    end
    if (r) begin
      mem_addr_q.delete();
      mem_due_q.delete();
      exp_pc     = RESET_PC;
      exp_req_pc = RESET_PC;
    end else begin
      if (obs_req === 1'b1 && obs_gnt) begin
        mem_addr_q.push_back(obs_addr);
        mem_due_q.push_back(cyc + mem_lat);
        exp_req_pc = exp_req_pc + 32'd4;
      end
      if (rd) begin
        exp_pc     = rpc & ~32'h3;
        exp_req_pc = rpc & ~32'h3;
      end
    end
    prev_redirect = rd && !r;
    cyc++;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b0, 32'h0, 1'b1);
    tick(1'b1, 1'b0, 32'h0, 1'b1);
    tests_run++;
    if (obs_req !== 1'b0) begin
      tests_failed++; $display("FAIL reset_req: imem_req=%b want 0", obs_req);
    end
    tests_run++;
    if (obs_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_valid: id_valid=%b want 0", obs_valid);
    end
    tests_run++;
    if (obs_inst !== NOP || obs_pc !== 32'h0) begin
      tests_failed++; $display("FAIL reset_id: id_inst=%h id_pc=%h want %h 0", obs_inst, obs_pc, NOP);
    end
    tests_run++;
    if (obs_addr !== RESET_PC) begin
      tests_failed++; $display("FAIL reset_addr: imem_addr=%h want %h", obs_addr, RESET_PC);
    end
  endtask

  task automatic test_stream();
    mem_lat = 1;
    gnt_pct = 100;
    for (int k = 0; k < 20; k++) begin
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      tests_run++;
      if (obs_req !== 1'b1 || obs_addr !== RESET_PC + 32'(4 * k)) begin
        tests_failed++;
        $display("FAIL stream_req: k=%0d req=%b addr=%h want 1 %h", k, obs_req, obs_addr, RESET_PC + 32'(4 * k));
      end
      tests_run++;
      if (obs_valid !== (k >= 2)) begin
        tests_failed++; $display("FAIL stream_valid: k=%0d id_valid=%b want %b", k, obs_valid, k >= 2);
      end
      if (k >= 2) begin
        tests_run++;
        if (obs_pc !== RESET_PC + 32'(4 * (k - 2))) begin
          tests_failed++;
          $display("FAIL stream_pc: k=%0d id_pc=%h want %h", k, obs_pc, RESET_PC + 32'(4 * (k - 2)));
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] head;
    head = exp_pc;
    for (int k = 0; k < 6; k++) begin
      tick(1'b0, 1'b0, 32'h0, 1'b0);
      tests_run++;
      if (obs_valid !== 1'b1 || obs_pc !== head) begin
        tests_failed++; $display("FAIL stall_head: k=%0d valid=%b pc=%h want 1 %h", k, obs_valid, obs_pc, head);
      end
    end
    tests_run++;
    if (obs_req !== 1'b0) begin
      tests_failed++; $display("FAIL stall_req: imem_req=%b want 0 after credit exhausted", obs_req);
    end
    for (int k = 0; k < 6; k++) begin
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      tests_run++;
      if (obs_valid !== 1'b1 || obs_pc !== head + 32'(4 * k)) begin
        tests_failed++;
        $display("FAIL stall_release: k=%0d valid=%b pc=%h want 1 %h", k, obs_valid, obs_pc, head + 32'(4 * k));
      end
    end
  endtask

  task automatic test_redirect_latency();
    bit found = 1'b0;
    bit seen  = 1'b0;
    mem_lat = 3;
    for (int k = 0; k < 20 && !found; k++) begin
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      if (mem_addr_q.size() == 2) found = 1'b1;
    end
    tests_run++;
    if (!found) begin
      tests_failed++; $display("FAIL redir_lat_setup: in-flight=%0d want 2 within 20 cycles", mem_addr_q.size());
    end
    tick(1'b0, 1'b1, 32'h0000_0100, 1'b1);
    tests_run++;
    if (obs_req !== 1'b0) begin
      tests_failed++; $display("FAIL redir_lat_req: imem_req=%b in redirect cycle want 0", obs_req);
    end
    for (int k = 0; k < 40 && !seen; k++) begin
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      if (obs_valid === 1'b1) begin
        seen = 1'b1;
        tests_run++;
        if (obs_pc !== 32'h0000_0100) begin
          tests_failed++; $display("FAIL redir_lat_first: id_pc=%h want 00000100", obs_pc);
        end
      end
    end
    tests_run++;
    if (!seen) begin
      tests_failed++; $display("FAIL redir_lat_timeout: delivered=%0d want first entry within 40 cycles", 0);
    end
  endtask

  task automatic test_redirect_rvalid();
    bit found = 1'b0;
    bit seen  = 1'b0;
    int d0;
    mem_lat = 2;
    for (int k = 0; k < 20 && !found; k++) begin
      if (rvalid_due()) begin
        found = 1'b1;
        tick(1'b0, 1'b1, 32'h0000_0203, 1'b1);
      end else begin
        tick(1'b0, 1'b0, 32'h0, 1'b1);
      end
    end
    tests_run++;
    if (!found) begin
      tests_failed++; $display("FAIL redir_rv_setup: no rvalid cycle found, got 0 want 1");
    end
    for (int k = 0; k < 30 && !seen; k++) begin
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      if (obs_valid === 1'b1) begin
        seen = 1'b1;
        tests_run++;
        if (obs_pc !== 32'h0000_0200) begin
          tests_failed++; $display("FAIL redir_rv_first: id_pc=%h want 00000200", obs_pc);
        end
      end
    end
    d0 = delivered;
    for (int k = 0; k < 15; k++) tick(1'b0, 1'b0, 32'h0, 1'b1);
    tests_run++;
    if (!seen || delivered - d0 < 3) begin
      tests_failed++; $display("FAIL redir_rv_progress: seen=%b delivered=%0d want 1 and >=3", seen, delivered - d0);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] got [$];
    logic [31:0] want [3];
    want[0] = 32'hFFFF_FFF8;
    want[1] = 32'hFFFF_FFFC;
    want[2] = 32'h0000_0000;
    mem_lat = 1;
    tick(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
    for (int k = 0; k < 30 && got.size() < 3; k++) begin
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      if (obs_req === 1'b1 && obs_gnt) got.push_back(obs_addr);
    end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (got.size() <= i || got[i] !== want[i]) begin
        tests_failed++;
        $display("FAIL wrap_addr: idx=%0d got=%h want %h", i, (got.size() > i) ? got[i] : 32'hx, want[i]);
      end
    end
    for (int k = 0; k < 6; k++) tick(1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_reset_midstream();
    bit seen = 1'b0;
    mem_lat = 1;
    for (int k = 0; k < 6; k++) tick(1'b0, 1'b0, 32'h0, 1'b0);
    tests_run++;
    if (obs_valid !== 1'b1 || obs_req !== 1'b0) begin
      tests_failed++; $display("FAIL rstmid_full: valid=%b req=%b want 1 0", obs_valid, obs_req);
    end
    tick(1'b1, 1'b0, 32'h0, 1'b1);
    tests_run++;
    if (obs_valid !== 1'b0 || obs_req !== 1'b0) begin
      tests_failed++; $display("FAIL rstmid_during: valid=%b req=%b want 0 0", obs_valid, obs_req);
    end
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    tests_run++;
    if (obs_valid !== 1'b0 || obs_inst !== NOP || obs_pc !== 32'h0 || obs_addr !== RESET_PC) begin
      tests_failed++;
      $display("FAIL rstmid_after: valid=%b inst=%h pc=%h addr=%h want 0 %h 0 %h", obs_valid, obs_inst, obs_pc, obs_addr, NOP, RESET_PC);
    end
    for (int k = 0; k < 10 && !seen; k++) begin
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      if (obs_valid === 1'b1) begin
        seen = 1'b1;
        tests_run++;
        if (obs_pc !== RESET_PC) begin
          tests_failed++; $display("FAIL rstmid_restart: id_pc=%h want %h", obs_pc, RESET_PC);
        end
      end
    end
    tests_run++;
    if (!seen) begin
      tests_failed++; $display("FAIL rstmid_timeout: seen=%b want 1 within 10 cycles", seen);
    end
  endtask

  task automatic test_random();
    int d0;
    bit rdy, rd;
    d0 = delivered;
    gnt_pct = 70;
    for (int k = 0; k < 1500; k++) begin
      if (k % 100 == 0) mem_lat = $urandom_range(1, 4);
      rdy = ($urandom_range(99) < 75);
      rd  = ($urandom_range(99) < 3);
      tick(1'b0, rd, $urandom, rdy);
    end
    tests_run++;
    if (delivered - d0 < 100) begin
      tests_failed++; $display("FAIL random_progress: delivered=%0d want >=100", delivered - d0);
    end
    gnt_pct = 100;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_latency();
    test_redirect_rvalid();
    test_wrap();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
